uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter and sequencer that shares the single UART transmitter among N_REQ byte producers (firmware mailbox, loopback echo, debug trace, etc.). It accepts one byte at a time from the winning requester, drives the transmitter's byte and start inputs, and tracks the start-clear and busy handshake until the frame completes. It detects a transmitter that never goes busy, then hands the transmitter to the next requester. It sits between the requesters and the UART TX core, alongside the Wishbone UART control registers.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- BUSY_TIMEOUT, 16: cycles allowed from start assertion to i_tx_busy rising before the byte is abandoned.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  N_REQ  requester k has a byte pending.
- i_req_data  in  8*N_REQ  byte of requester k on bits [8k+7:8k].
- o_req_ready  out  N_REQ  one-hot; byte k is transferred on a clock edge where valid[k] and ready[k] are both high.
- o_tx  out  8  byte to the transmitter.
- o_tx_start  out  1  transmit request, level, held until acknowledged.
- i_tx_start_clear  in  1  transmitter has latched the start request.
- i_tx_busy  in  1  transmitter is shifting a frame.
- i_err_clr  in  1  clears o_timeout_err.
- o_grant  out  N_REQ  one-hot owner of the transaction in flight; 0 when idle.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout_err  out  1  sticky; a granted byte was dropped on timeout.
- o_sent_cnt  out  16  count of completed frames; wraps 0xFFFF to 0x0000.

## Operation
- States:
  - IDLE: waiting for a requester.
  - START: o_tx_start=1.
  - WAIT_BUSY: start acknowledged, busy not yet seen.
  - WAIT_DONE: frame in progress.
- IDLE arbitration:
  - Eligible only when i_tx_busy=0.
  - Winner is the first k with valid[k]=1, scanning from ptr+1 upward modulo N_REQ. ptr is the last granted index.
  - o_req_ready is combinational: ready[winner]=1, all other bits 0.
  - o_req_ready is all-zero outside IDLE, while i_tx_busy=1, and while rst_n=0.
- On transfer:
  - Latch the winner's byte into o_tx.
  - Set o_grant to the winner and ptr to the winner.
  - Clear the timeout counter.
  - Next state START.
- START:
  - If i_tx_busy=1, go to WAIT_DONE.
  - Else if i_tx_start_clear=1, go to WAIT_BUSY.
  - o_tx_start drops on the same edge as either transition.
- WAIT_BUSY: if i_tx_busy=1, go to WAIT_DONE.
- Timeout:
  - The counter increments every cycle in START and WAIT_BUSY.
  - When it reaches BUSY_TIMEOUT-1 without busy, go to IDLE: o_tx_start=0, o_grant=0, o_timeout_err=1.
  - The byte is dropped; o_sent_cnt is unchanged.
- WAIT_DONE: when i_tx_busy=0, go to IDLE, clear o_grant, and increment o_sent_cnt.
- o_tx holds the last latched byte until the next transfer.
- A requester may drop valid before receiving ready. No byte is taken and no state changes.
- i_err_clr and a timeout on the same edge: the set wins, so o_timeout_err stays 1.
- A requester with valid held continuously cannot win twice in a row while another requester has valid=1.
- Reset mid-operation:
  - All outputs return to reset values immediately and the state returns to IDLE.
  - The in-flight byte is lost.
  - No grant is issued until i_tx_busy=0.

## Timing
- Reset values: o_req_ready=0, o_tx=0x00, o_tx_start=0, o_grant=0, o_busy=0, o_timeout_err=0, o_sent_cnt=0, ptr=N_REQ-1 (requester 0 wins first).
- Transfer at edge T: o_tx, o_grant, o_tx_start and o_busy are valid from T+1.
- Earliest next transfer: the cycle after i_tx_busy is sampled low in WAIT_DONE, i.e. one idle cycle minimum between frames.
- Timeout: the last cycle with o_tx_start=1 is at most BUSY_TIMEOUT cycles after T. o_timeout_err is set on the following edge.
- All outputs except o_req_ready are registered.

## Test plan
- **Single requester:** req0 valid with 0xA5 → ready[0] for one cycle, o_tx=0xA5 and o_tx_start=1 on the next cycle. Then i_tx_start_clear, busy high for 10 cycles, busy low → o_sent_cnt=1, o_grant=0.
- **Round-robin fairness:** all four requesters valid and held, bytes 0x10..0x13 → transmit order 0,1,2,3,0. Each ready pulse occurs exactly once per frame.
- **Pointer continuity:** after a grant to 2, assert valid on 0 and 3 simultaneously → 3 wins, then 0.
- **Timeout:** start without busy ever asserting → o_tx_start drops after BUSY_TIMEOUT=16 cycles and o_timeout_err=1. o_sent_cnt is unchanged. Asserting i_err_clr on the same cycle as a second timeout leaves o_timeout_err=1.
- **Reset mid-frame:** rst_n low during WAIT_DONE → all outputs are 0 asynchronously. After release with i_tx_busy still high, no ready is issued until busy falls.
- **Counter wrap:** preload by running 65536 frames (or force the count) → o_sent_cnt goes 0xFFFF → 0x0000.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter handshake bundle for the shared UART TX arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   i_req_valid;
  logic [8*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]   o_req_ready;
  logic [7:0]         o_tx;
  logic               o_tx_start;
  logic               i_tx_start_clear;
  logic               i_tx_busy;

  modport master (
    output i_req_valid, i_req_data, i_tx_start_clear, i_tx_busy,
    input  o_req_ready, o_tx, o_tx_start
  );

  modport slave (
    input  i_req_valid, i_req_data, i_tx_start_clear, i_tx_busy,
    output o_req_ready, o_tx, o_tx_start
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers,
// with start/busy handshake tracking and a busy-never-rose timeout.
module uart_tx_arb #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arb_if.slave      bus,
  input  logic              i_err_clr,
  output logic [N_REQ-1:0]  o_grant,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic [15:0]       o_sent_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TO_W  = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [7:0]         tx_d;
  logic               start_d;
  logic [N_REQ-1:0]   grant_d;
  logic               busy_d;
  logic               err_d;
  logic [15:0]        cnt_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [N_REQ-1:0]   ready_c;
  logic               xfer_c;
  int unsigned        cand;

  // Winner: first valid requester after the last granted one, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!win_found && bus.i_req_valid[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    ready_c = '0;
    if (rst_n && state_q == S_IDLE && !bus.i_tx_busy && win_found)
      ready_c = N_REQ'(1) << win_idx;
  end

  assign bus.o_req_ready = ready_c;
  assign xfer_c          = |(ready_c & bus.i_req_valid);

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    to_cnt_d = to_cnt_q;
    tx_d     = bus.o_tx;
    grant_d  = o_grant;
    cnt_d    = o_sent_cnt;
    err_d    = o_timeout_err;
    if (i_err_clr)
      err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          for (int k = 0; k < int'(N_REQ); k++)
            if (win_idx == PTR_W'(k))
              tx_d = bus.i_req_data[k*8 +: 8];
          grant_d  = ready_c;
          ptr_d    = win_idx;
          to_cnt_d = '0;
          state_d  = S_START;
        end
      end
      S_START, S_WAIT_BUSY: begin
        if (bus.i_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          // Transmitter never went busy: drop the byte, a pending clear loses to the set.
          state_d = S_IDLE;
          grant_d = '0;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (state_q == S_START && bus.i_tx_start_clear)
            state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = o_sent_cnt + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= PTR_RESET;
      to_cnt_q       <= '0;
      bus.o_tx       <= 8'h00;
      bus.o_tx_start <= 1'b0;
      o_grant        <= '0;
      o_busy         <= 1'b0;
      o_timeout_err  <= 1'b0;
      o_sent_cnt     <= 16'h0000;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      to_cnt_q       <= to_cnt_d;
      bus.o_tx       <= tx_d;
      bus.o_tx_start <= start_d;
      o_grant        <= grant_d;
      o_busy         <= busy_d;
      o_timeout_err  <= err_d;
      o_sent_cnt     <= cnt_d;
    end
  end

endmodule
